dds_wb_cfg_master: RTL and testbench
====================================

// Module: dds_wb_cfg_master
// PURPOSE
// Wishbone initiator that programs a simple_dds register file from a single start request.
// - Polls READY until bit 0 reads 1, then writes DDS_SRC, TUNING_WORD, GAIN_WORD, OFFSET_WORD and ENABLE, in that order.
// - Lets a host, sequencer or SoC glue configure a DDS channel without driving bus cycles itself.
// - Connects directly to the simple_dds Wishbone slave port.
// PARAMETERS
// DATA_WIDTH    32   Wishbone data width; >= 16
// ADDR_WIDTH    16   Wishbone address width
// ACK_TIMEOUT   16   max cycles stb_o may wait for ack_i before abort; >= 2
// MAX_POLLS     64   max READY reads before abort; >= 1
// POLL_GAP      4    idle cycles between consecutive READY reads; >= 1
// PORTS
// wb_clk_i      in   1           clock; all logic on rising edge
// wb_rst_n_i    in   1           asynchronous active-low reset
// start_i       in   1           one-cycle request; sampled only in IDLE
// dds_src_i     in   2           waveform select, latched on accepted start
// tuning_i      in   8           tuning word, latched on accepted start
// gain_i        in   2           gain select, latched on accepted start
// offset_i      in   16          offset word, latched on accepted start
// enable_i      in   1           value written to ENABLE bit 0, latched on accepted start
// busy_o        out  1           high from the cycle after an accepted start until DONE or ERROR
// done_o        out  1           one-cycle pulse when the sequence completes
// err_o         out  2           sticky error: 01 ack timeout, 10 poll limit; cleared on accepted start
// wb_addr_o     out  ADDR_WIDTH  register address
// wb_dat_o      out  DATA_WIDTH  write data, zero-extended fields
// wb_we_o       out  1           1 = write, 0 = read
// wb_stb_o      out  1           strobe
// wb_dat_i      in   DATA_WIDTH  read data
// wb_ack_i      in   1           slave acknowledge
// BEHAVIOUR
// - Reset (async, immediate): all outputs 0; FSM in IDLE; latched config 0; counters 0. A mid-transfer reset drops stb_o at once.
// - All outputs are registered.
// - FSM states: IDLE, RD_REQ, RD_WAIT, GAP, WR_REQ, WR_WAIT, DONE, ERROR.
// - IDLE: start_i=1 latches inputs, clears err_o, clears poll_cnt and wr_idx, goes to RD_REQ.
// - RD_REQ (1 cycle): drive addr=0, we=0, stb=1; go to RD_WAIT.
// - RD_WAIT: hold stb/addr/we. On ack_i=1, drop stb at that edge and poll_cnt++.
//   - dat_i[0]=1: go to WR_REQ.
//   - dat_i[0]=0 and poll_cnt+1 == MAX_POLLS: err_o=10, go to ERROR.
//   - otherwise: go to GAP.
// - GAP: stb=0 for POLL_GAP cycles, then RD_REQ.
// - WR_REQ (1 cycle): we=1, stb=1, addr/dat chosen by wr_idx:
//   - 0 -> addr 2, dds_src
//   - 1 -> addr 3, tuning
//   - 2 -> addr 4, gain
//   - 3 -> addr 5, offset
//   - 4 -> addr 1, enable
// - WR_WAIT: hold bus. On ack_i=1, drop stb. If wr_idx==4 go to DONE, else wr_idx++ and go to WR_REQ.
// - Inter-transfer spacing: stb_o is low at least one cycle between transfers (the REQ states re-raise it).
// - Ack timeout: a wait counter starts when stb_o rises and increments every cycle while waiting.
//   - When it reaches ACK_TIMEOUT without ack: err_o=01, stb=0, go to ERROR.
//   - ack_i arriving on the timeout cycle counts as success.
// - DONE: done_o=1 for one cycle, busy_o=0, return to IDLE.
// - ERROR: one cycle, then IDLE. busy_o=0; err_o holds until the next accepted start.
// - Ignored inputs:
//   - start_i outside IDLE (no queueing).
//   - ack_i while stb_o=0.
//   - wb_dat_i except in RD_WAIT.
// - While stb_o=0: wb_we_o=0; wb_dat_o and wb_addr_o hold their last values.
// TESTING
// 1. Ready immediately: slave READY=1, start with src=1, tuning=0x2A, gain=2, offset=0x1234, enable=1.
//    -> writes (2,1),(3,0x2A),(4,2),(5,0x1234),(1,1) in order; done_o pulses once; err_o=00.
// 2. Delayed ready: READY reads 0 three times, then 1.
//    -> exactly 4 reads spaced >= POLL_GAP idle cycles; then the 5 writes.
// 3. Never ready, MAX_POLLS=4 -> 4 reads, no writes, err_o=10, busy_o falls, no done_o.
// 4. Slave withholds ack on the TUNING_WORD write -> stb_o drops after 16 cycles, err_o=01, OFFSET and ENABLE never written.
// 5. start_i pulsed while busy, inputs changed -> ignored; written values equal those latched at the first start.
// 6. wb_rst_n_i low during WR_WAIT -> stb_o=0 with no clock edge; after release, idle until start_i and restarts from READY polling.

Source files
------------

// File: rtl/dds_wb_cfg_master.sv
// dds_wb_cfg_master
// Wishbone initiator that configures one simple_dds channel from a single
// start request. It polls READY (addr 0) until bit 0 reads 1. It then writes
// DDS_SRC (2), TUNING_WORD (3), GAIN_WORD (4), OFFSET_WORD (5) and ENABLE (1),
// in that order.
//
// Ports
//   wb_clk_i, wb_rst_n_i  clock (rising edge), asynchronous active-low reset
//   start_i               one-cycle request, sampled only in IDLE
//   dds_src_i .. enable_i configuration fields, latched on an accepted start
//   busy_o                high from the cycle after an accepted start until DONE/ERROR
//   done_o                one-cycle pulse when the sequence completes
//   err_o                 sticky: 01 ack timeout, 10 poll limit; cleared on start
//   wb_addr_o/wb_dat_o/wb_we_o/wb_stb_o  Wishbone request (all registered)
//   wb_dat_i/wb_ack_i     Wishbone response
//   dbg_state_o           current FSM state, for debug and checkers
//
// Handshake: a transfer begins when wb_stb_o rises. The request is held
// unchanged until wb_ack_i is seen high at a clock edge while wb_stb_o is high.
// wb_stb_o drops at that same edge. wb_ack_i is ignored whenever wb_stb_o is low.
// wb_stb_o is always low for at least one cycle between two transfers.
module dds_wb_cfg_master #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_POLLS   = 64,
    parameter int POLL_GAP    = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic                  start_i,
    input  logic [1:0]            dds_src_i,
    input  logic [7:0]            tuning_i,
    input  logic [1:0]            gain_i,
    input  logic [15:0]           offset_i,
    input  logic                  enable_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            err_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_we_o,
    output logic                  wb_stb_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    output logic [2:0]            dbg_state_o
);

    localparam int WCW = $clog2(ACK_TIMEOUT + 1);
    localparam int PCW = $clog2(MAX_POLLS + 1);
    localparam int GCW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_GAP, S_WR_REQ, S_WR_WAIT, S_DONE, S_ERROR
    } state_t;

    state_t                r_state, w_nxt_state;
    logic [1:0]            r_src;
    logic [7:0]            r_tun;
    logic [1:0]            r_gain;
    logic [15:0]           r_off;
    logic                  r_en;
    logic [PCW-1:0]        r_poll_cnt, w_nxt_poll;
    logic [2:0]            r_wr_idx, w_nxt_wr_idx;
    logic [WCW-1:0]        r_wait_cnt, w_nxt_wait;
    logic [GCW-1:0]        r_gap_cnt, w_nxt_gap;
    logic                  r_busy, w_nxt_busy;
    logic                  r_done, w_nxt_done;
    logic [1:0]            r_err, w_nxt_err;
    logic [ADDR_WIDTH-1:0] r_addr, w_nxt_addr, w_wr_addr;
    logic [DATA_WIDTH-1:0] r_dat, w_nxt_dat, w_wr_dat;
    logic                  r_we, w_nxt_we;
    logic                  r_stb, w_nxt_stb;
    logic                  w_latch;
    logic                  w_unused_dat;

    // Only READY bit 0 carries meaning; the rest of the read data is don't-care.
    assign w_unused_dat = ^wb_dat_i[DATA_WIDTH-1:1];

    // Register address and zero-extended data for the current write slot.
    always_comb begin
        w_wr_addr = '0;
        w_wr_dat  = '0;
        case (r_wr_idx)
            3'd0: begin w_wr_addr = ADDR_WIDTH'(2); w_wr_dat = DATA_WIDTH'(r_src);  end
            3'd1: begin w_wr_addr = ADDR_WIDTH'(3); w_wr_dat = DATA_WIDTH'(r_tun);  end
            3'd2: begin w_wr_addr = ADDR_WIDTH'(4); w_wr_dat = DATA_WIDTH'(r_gain); end
            3'd3: begin w_wr_addr = ADDR_WIDTH'(5); w_wr_dat = DATA_WIDTH'(r_off);  end
            default: begin w_wr_addr = ADDR_WIDTH'(1); w_wr_dat = DATA_WIDTH'(r_en); end
        endcase
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_poll   = r_poll_cnt;
        w_nxt_wr_idx = r_wr_idx;
        w_nxt_wait   = r_wait_cnt;
        w_nxt_gap    = r_gap_cnt;
        w_nxt_err    = r_err;
        w_nxt_addr   = r_addr;
        w_nxt_dat    = r_dat;
        w_nxt_we     = r_we;
        w_nxt_stb    = r_stb;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_latch      = 1'b1;
                    w_nxt_err    = 2'b00;
                    w_nxt_poll   = '0;
                    w_nxt_wr_idx = '0;
                    w_nxt_state  = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                w_nxt_addr  = '0;
                w_nxt_we    = 1'b0;
                w_nxt_stb   = 1'b1;
                w_nxt_wait  = '0;
                w_nxt_state = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                // An ack on the final timeout cycle still counts as success.
                if (wb_ack_i) begin
                    w_nxt_stb  = 1'b0;
                    w_nxt_poll = r_poll_cnt + 1'b1;
                    if (wb_dat_i[0]) begin
                        w_nxt_state = S_WR_REQ;
                    end else if (r_poll_cnt == PCW'(MAX_POLLS - 1)) begin
                        w_nxt_err   = 2'b10;
                        w_nxt_state = S_ERROR;
                    end else begin
                        w_nxt_gap   = '0;
                        w_nxt_state = S_GAP;
                    end
                end else if (r_wait_cnt == WCW'(ACK_TIMEOUT - 1)) begin
                    w_nxt_stb   = 1'b0;
                    w_nxt_err   = 2'b01;
                    w_nxt_state = S_ERROR;
                end else begin
                    w_nxt_wait = r_wait_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GCW'(POLL_GAP - 1)) begin
                    w_nxt_state = S_RD_REQ;
                end else begin
                    w_nxt_gap = r_gap_cnt + 1'b1;
                end
            end
            S_WR_REQ: begin
                w_nxt_addr  = w_wr_addr;
                w_nxt_dat   = w_wr_dat;
                w_nxt_we    = 1'b1;
                w_nxt_stb   = 1'b1;
                w_nxt_wait  = '0;
                w_nxt_state = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (wb_ack_i) begin
                    w_nxt_stb = 1'b0;
                    w_nxt_we  = 1'b0;
                    if (r_wr_idx == 3'd4) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_wr_idx = r_wr_idx + 3'd1;
                        w_nxt_state  = S_WR_REQ;
                    end
                end else if (r_wait_cnt == WCW'(ACK_TIMEOUT - 1)) begin
                    w_nxt_stb   = 1'b0;
                    w_nxt_we    = 1'b0;
                    w_nxt_err   = 2'b01;
                    w_nxt_state = S_ERROR;
                end else begin
                    w_nxt_wait = r_wait_cnt + 1'b1;
                end
            end
            S_DONE:  w_nxt_state = S_IDLE;
            S_ERROR: w_nxt_state = S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
        // busy and done are decoded from the next state so that they line up
        // with the registered state rather than lagging it by a cycle.
        w_nxt_busy = !(w_nxt_state inside {S_IDLE, S_DONE, S_ERROR});
        w_nxt_done = (w_nxt_state == S_DONE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_tun      <= '0;
            r_gain     <= '0;
            r_off      <= '0;
            r_en       <= 1'b0;
            r_poll_cnt <= '0;
            r_wr_idx   <= '0;
            r_wait_cnt <= '0;
            r_gap_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 2'b00;
            r_addr     <= '0;
            r_dat      <= '0;
            r_we       <= 1'b0;
            r_stb      <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_poll_cnt <= w_nxt_poll;
            r_wr_idx   <= w_nxt_wr_idx;
            r_wait_cnt <= w_nxt_wait;
            r_gap_cnt  <= w_nxt_gap;
            r_busy     <= w_nxt_busy;
            r_done     <= w_nxt_done;
            r_err      <= w_nxt_err;
            r_addr     <= w_nxt_addr;
            r_dat      <= w_nxt_dat;
            r_we       <= w_nxt_we;
            r_stb      <= w_nxt_stb;
            if (w_latch) begin
                r_src  <= dds_src_i;
                r_tun  <= tuning_i;
                r_gain <= gain_i;
                r_off  <= offset_i;
                r_en   <= enable_i;
            end
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign wb_addr_o   = r_addr;
    assign wb_dat_o    = r_dat;
    assign wb_we_o     = r_we;
    assign wb_stb_o    = r_stb;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dds_wb_cfg_master.sv
// Testbench for dds_wb_cfg_master. A behavioural simple_dds slave answers
// bus cycles and logs every transfer. A reference model derives the expected
// transfer list from the configuration and the slave's behaviour.
module tb_dds_wb_cfg_master;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int AT = 16;
    localparam int MP = 4;
    localparam int PG = 4;
    localparam int TW = 1 + AW + DW;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start_i, enable_i;
    logic [1:0]    dds_src_i, gain_i;
    logic [7:0]    tuning_i;
    logic [15:0]   offset_i;
    logic          busy_o, done_o;
    logic [1:0]    err_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic          wb_we_o, wb_stb_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic [2:0]    dbg_state_o;

    dds_wb_cfg_master #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACK_TIMEOUT(AT), .MAX_POLLS(MP), .POLL_GAP(PG)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start_i),
        .dds_src_i(dds_src_i), .tuning_i(tuning_i), .gain_i(gain_i),
        .offset_i(offset_i), .enable_i(enable_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .dbg_state_o(dbg_state_o)
    );

    typedef struct {
        logic [1:0]  src;
        logic [7:0]  tun;
        logic [1:0]  gain;
        logic [15:0] off;
        logic        en;
        int          ready_after; // READY reads returning 0 before the first 1
        int          lat;         // ack on the (lat+1)-th strobe cycle
        int          withhold;    // write index never acked, -1 = none
        bit          mid_start;
        bit          spur;        // spurious acks while stb is low
        logic [1:0]  exp_err;
        int          exp_done;
    } vec_t;

    // scoreboard
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] act_q[$];
    int n_pass = 0;
    int n_total = 0;

    // slave configuration and observations
    int cfg_ready_after, cfg_lat, cfg_withhold;
    bit cfg_spur;
    int s_rd_n, s_wr_n, n_done, viol, to_len, rd_end_cyc;
    bit have_rd_end;
    int model_err, model_done;
    bit model_to;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: READY is sampled until it reads 1 or MAX_POLLS reads
    // have been made. Then the five writes follow, stopping at the first write
    // the slave refuses to acknowledge.
    function automatic void build_model(input vec_t v);
        int addrs[5] = '{2, 3, 4, 5, 1};
        logic [DW-1:0] vals[5];
        logic [AW-1:0] a;
        bit ready;
        int nreads;
        vals[0] = DW'(v.src);
        vals[1] = DW'(v.tun);
        vals[2] = DW'(v.gain);
        vals[3] = DW'(v.off);
        vals[4] = DW'(v.en);
        exp_q.delete();
        ready  = (v.ready_after < MP);
        nreads = ready ? v.ready_after + 1 : MP;
        for (int i = 0; i < nreads; i++) exp_q.push_back({TW{1'b0}});
        model_to = ready && (v.withhold >= 0) && (v.withhold <= 4);
        if (ready) begin
            for (int i = 0; i < 5; i++) begin
                a = AW'(addrs[i]);
                exp_q.push_back({1'b1, a, vals[i]});
                if (i == v.withhold) break;
            end
        end
        model_err  = !ready ? 2 : (model_to ? 1 : 0);
        model_done = (model_err == 0) ? 1 : 0;
    endfunction

    // Behavioural slave and bus monitor, sampled 1 time unit after each edge.
    initial begin : slave
        int s_cnt, cyc;
        bit s_hold, cur_rd;
        logic [DW-1:0] s_dat, d;
        logic [AW-1:0] last_addr;
        logic [DW-1:0] last_dat;
        s_cnt = 0; cyc = 0; s_hold = 0; cur_rd = 0; s_dat = '0;
        last_addr = '0; last_dat = '0;
        wb_ack_i = 1'b0;
        wb_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                s_cnt = 0;
                wb_ack_i = 1'b0;
                last_addr = '0;
                last_dat = '0;
            end else begin
                if (done_o) n_done++;
                if (done_o && busy_o) viol++;
                if (wb_stb_o) begin
                    s_cnt++;
                    last_addr = wb_addr_o;
                    last_dat  = wb_dat_o;
                    if (s_cnt == 1) begin
                        d = wb_we_o ? wb_dat_o : {DW{1'b0}};
                        act_q.push_back({wb_we_o, wb_addr_o, d});
                        cur_rd = !wb_we_o;
                        if (wb_we_o) begin
                            s_hold = (s_wr_n == cfg_withhold);
                            s_wr_n++;
                        end else begin
                            s_hold = 1'b0;
                            s_dat = $urandom;
                            s_dat[0] = (s_rd_n >= cfg_ready_after);
                            s_rd_n++;
                            if (have_rd_end && (cyc - rd_end_cyc) < PG) viol++;
                        end
                    end
                    if (!s_hold && s_cnt == cfg_lat + 1) begin
                        wb_ack_i = 1'b1;
                        wb_dat_i = wb_we_o ? $urandom : s_dat;
                    end else begin
                        wb_ack_i = 1'b0;
                        wb_dat_i = $urandom;
                    end
                end else begin
                    if (wb_we_o || wb_addr_o !== last_addr || wb_dat_o !== last_dat) viol++;
                    if (s_cnt > 0) begin
                        if (s_hold) to_len = s_cnt;
                        if (cur_rd) begin
                            have_rd_end = 1'b1;
                            rd_end_cyc  = cyc;
                        end
                    end
                    s_cnt = 0;
                    wb_ack_i = cfg_spur ? 1'($urandom_range(0, 1)) : 1'b0;
                    wb_dat_i = $urandom;
                end
            end
        end
    end

    task automatic set_slave(input vec_t v);
        cfg_ready_after = v.ready_after;
        cfg_lat = v.lat;
        cfg_withhold = v.withhold;
        cfg_spur = v.spur;
        s_rd_n = 0; s_wr_n = 0; n_done = 0; viol = 0; to_len = -1; have_rd_end = 0;
        act_q.delete();
    endtask

    task automatic run_case(input vec_t v, input string tag);
        int cyc;
        int n;
        build_model(v);
        set_slave(v);
        dds_src_i = v.src; tuning_i = v.tun; gain_i = v.gain; offset_i = v.off; enable_i = v.en;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check({tag, "/busy_after_start"}, busy_o, 1);
        check({tag, "/err_cleared"}, err_o, 0);
        // Inputs change after acceptance and must have no effect.
        dds_src_i = ~v.src; tuning_i = ~v.tun; gain_i = ~v.gain; offset_i = ~v.off; enable_i = ~v.en;
        cyc = 0;
        while (busy_o && cyc < 3000) begin
            start_i = (v.mid_start && cyc == 4);
            @(posedge clk); #1;
            cyc++;
        end
        start_i = 1'b0;
        check({tag, "/finished_in_bound"}, busy_o, 0);
        repeat (6) @(posedge clk);
        #1;
        check({tag, "/err"}, err_o, v.exp_err);
        check({tag, "/done_pulses"}, n_done, v.exp_done);
        check({tag, "/xfer_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s/xfer%0d", tag, i), act_q[i], exp_q[i]);
        check({tag, "/bus_rules"}, viol, 0);
        if (model_to) check({tag, "/timeout_len"}, to_len, AT);
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        int cyc;
        rst_n = 1'b0;
        start_i = 1'b0; dds_src_i = '0; tuning_i = '0; gain_i = '0; offset_i = '0; enable_i = 1'b0;
        cfg_ready_after = 0; cfg_lat = 0; cfg_withhold = -1; cfg_spur = 0;
        s_rd_n = 0; s_wr_n = 0; n_done = 0; viol = 0; to_len = -1; have_rd_end = 0;

        //          src  tun    gain off       en  rdy  lat   wh  mid spur err    done
        vecs[0] = '{2'd1, 8'h2A, 2'd2, 16'h1234, 1'b1, 0,   0,   -1, 0,  0,  2'b00, 1};
        vecs[1] = '{2'd2, 8'h55, 2'd1, 16'hBEEF, 1'b1, 3,   1,   -1, 0,  0,  2'b00, 1};
        vecs[2] = '{2'd3, 8'h01, 2'd0, 16'h0001, 1'b0, 100, 0,   -1, 0,  0,  2'b10, 0};
        vecs[3] = '{2'd1, 8'h7E, 2'd3, 16'h4242, 1'b1, 0,   0,   1,  0,  0,  2'b01, 0};
        vecs[4] = '{2'd0, 8'hC3, 2'd1, 16'h0F0F, 1'b1, 1,   2,   -1, 1,  0,  2'b00, 1};
        vecs[5] = '{2'd2, 8'h99, 2'd2, 16'hA5A5, 1'b0, 1,   AT-1,-1, 0,  0,  2'b00, 1};
        vecs[6] = '{2'd1, 8'h10, 2'd1, 16'h8000, 1'b1, 0,   3,   4,  0,  1,  2'b01, 0};
        vecs[7] = '{2'd3, 8'hFF, 2'd3, 16'hFFFF, 1'b0, 2,   0,   -1, 0,  1,  2'b00, 1};

        repeat (3) @(posedge clk);
        #1;
        check("reset/ctrl", {busy_o, done_o, err_o, wb_stb_o, wb_we_o}, 0);
        check("reset/bus", {wb_addr_o, wb_dat_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_case(vecs[i], $sformatf("dir%0d", i));

        // Reset while a write waits for ack: strobe must drop without a clock edge.
        v = vecs[0];
        v.lat = 8;
        set_slave(v);
        dds_src_i = v.src; tuning_i = v.tun; gain_i = v.gain; offset_i = v.off; enable_i = v.en;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        cyc = 0;
        while (!(wb_stb_o && wb_we_o) && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_mid/reached_write", wb_stb_o && wb_we_o, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid/async_ctrl", {busy_o, done_o, err_o, wb_stb_o, wb_we_o}, 0);
        check("rst_mid/async_bus", {wb_addr_o, wb_dat_o}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        act_q.delete();
        repeat (12) @(posedge clk);
        #1;
        check("rst_mid/idle_no_xfer", act_q.size(), 0);
        check("rst_mid/idle_not_busy", busy_o, 0);
        run_case(vecs[1], "after_rst");

        // Randomized runs checked against the reference model.
        for (int i = 0; i < 20; i++) begin
            v.src = 2'($urandom);
            v.tun = 8'($urandom);
            v.gain = 2'($urandom);
            v.off = 16'($urandom);
            v.en = 1'($urandom);
            v.ready_after = $urandom_range(0, MP + 1);
            v.lat = $urandom_range(0, AT - 1);
            v.withhold = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1;
            v.mid_start = 1'($urandom_range(0, 1));
            v.spur = 1'($urandom_range(0, 1));
            build_model(v);
            v.exp_err = 2'(model_err);
            v.exp_done = model_done;
            run_case(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
